id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, writeback capture
// bypass, EX operand forwarding muxes and a saturating bubble counter.
//
// Handshake: stall_if_id is the only upstream handshake. While it is high the
// PC and IF/ID register must hold, so the ID instruction is presented again on
// the next cycle. The EX register accepts the ID instruction on any edge where
// flush, stall_ext and the load-use hazard are all low; flush wins over
// stall_ext, which wins over the hazard.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_read_reg1,
  input  logic [4:0]  id_read_reg2,
  input  logic [4:0]  id_write_reg,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_alu_src,
  input  logic [3:0]  id_alu_op,
  input  logic [63:0] id_rd1,
  input  logic [63:0] id_rd2,
  input  logic [63:0] id_imm,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [63:0] wb_data,
  input  logic [63:0] exMem_alu_result,
  input  logic        forwardA,
  input  logic        forwardB,
  input  logic        flush,
  input  logic        stall_ext,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [4:0]  ex_read_reg1,
  output logic [4:0]  ex_read_reg2,
  output logic [4:0]  ex_write_reg,
  output logic [3:0]  ex_alu_op,
  output logic [63:0] ex_opA,
  output logic [63:0] ex_opB,
  output logic [63:0] ex_store_data,
  output logic        stall_if_id,
  output logic [15:0] bubble_count,
  output logic        dbg_state
);

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

  state_t      state_q;
  logic        ex_alu_src_q;
  logic [63:0] rd1_q;
  logic [63:0] rd2_q;
  logic [63:0] imm_q;
  logic [15:0] bubble_q;

  logic        hz;
  logic        cap_byp1;
  logic        cap_byp2;
  logic        wb_hit1;
  logic        wb_hit2;
  logic [63:0] fwd_b;

  // Hazard, capture-bypass and operand-forwarding decode; x0 never matches.
  always_comb begin
    hz = ex_valid && ex_mem_read && (ex_write_reg != 5'd0) && id_valid &&
         ((ex_write_reg == id_read_reg1) || (ex_write_reg == id_read_reg2));
    cap_byp1 = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_read_reg1);
    cap_byp2 = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_read_reg2);
    wb_hit1  = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == ex_read_reg1);
    wb_hit2  = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == ex_read_reg2);
    ex_opA   = forwardA ? exMem_alu_result : (wb_hit1 ? wb_data : rd1_q);
    fwd_b    = forwardB ? exMem_alu_result : (wb_hit2 ? wb_data : rd2_q);
    ex_store_data = fwd_b;
    ex_opB   = ex_alu_src_q ? imm_q : fwd_b;
    // A hazard can only be live in RUN: a bubble leaves ex_valid low.
    stall_if_id = !flush && (stall_ext || (hz && (state_q == ST_RUN)));
  end

  assign bubble_count = bubble_q;
  assign dbg_state    = state_q;

  // Pipeline register and RUN/BUBBLE sequencing, priority flush > stall_ext > hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src_q <= 1'b0;
      ex_read_reg1 <= 5'd0;
      ex_read_reg2 <= 5'd0;
      ex_write_reg <= 5'd0;
      ex_alu_op    <= 4'd0;
      rd1_q        <= 64'd0;
      rd2_q        <= 64'd0;
      imm_q        <= 64'd0;
      bubble_q     <= 16'd0;
    end else if (flush) begin
      // Squash: bubble without counting it as a load-use bubble.
      state_q      <= ST_RUN;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (stall_ext) begin
      // Downstream hold: everything keeps its value.
      state_q      <= state_q;
    end else if (hz && (state_q == ST_RUN)) begin
      state_q      <= ST_BUBBLE;
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      if (bubble_q != 16'hFFFF) begin
        bubble_q <= bubble_q + 16'd1;
      end
    end else begin
      state_q      <= ST_RUN;
      ex_valid     <= id_valid;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_alu_src_q <= id_alu_src;
      ex_read_reg1 <= id_read_reg1;
      ex_read_reg2 <= id_read_reg2;
      ex_write_reg <= id_write_reg;
      ex_alu_op    <= id_alu_op;
      rd1_q        <= cap_byp1 ? wb_data : id_rd1;
      rd2_q        <= cap_byp2 ? wb_data : id_rd2;
      imm_q        <= id_imm;
    end
  end

endmodule
